i2s_sample_feeder: RTL and testbench

- Upstream stage of the i2s serializer: buffers audio samples written by the j1a CPU in a small FIFO.
- Presents one sample per half-frame on a parallel bus, timed to the serializer's WIDTH-bit word cadence.
- Alternates left/right, and reports underrun and overflow so firmware can pace its writes.

---
 rtl/i2s_sample_feeder.sv | 165 ++++++++++++++++
 tb/tb_i2s_sample_feeder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/i2s_sample_feeder.sv
// Sample FIFO and half-frame pacer feeding the i2s serializer's parallel input.
// The CPU enqueues interleaved L/R samples; one is presented every WIDTH clocks.
module i2s_sample_feeder #(
    parameter int WIDTH         = 16,
    parameter int DEPTH_LOG2    = 4,
    parameter int UNDERRUN_ZERO = 1
) (
    input  logic                  clk,
    input  logic                  resetq,
    input  logic                  enable,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic [WIDTH-1:0]      sample,
    output logic                  sample_strobe,
    output logic                  lr,
    output logic                  underrun,
    output logic                  overflow,
    input  logic                  flags_clr
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sample_q, sample_d;
    logic             strobe_q, strobe_d;
    logic             lr_q, lr_d;
    logic             started_q, started_d;
    logic             underrun_q, underrun_d;
    logic             overflow_q, overflow_d;

    logic [PW-1:0]    level_s;
    logic             full_s;
    logic             empty_s;
    logic             boundary_s;
    logic             wr_accept_s;
    logic             wr_drop_s;
    logic             pop_s;
    logic             starve_s;

    // Occupancy derives only from registered pointers, so no input reaches full/empty/level.
    assign level_s     = wptr_q - rptr_q;
    assign full_s      = (level_s == PW'(DEPTH));
    assign empty_s     = (level_s == {PW{1'b0}});
    assign boundary_s  = enable && (cnt_q == CW'(WIDTH - 1));
    assign wr_accept_s = wr_en && !full_s;
    assign wr_drop_s   = wr_en && full_s;
    assign pop_s       = boundary_s && !empty_s;
    assign starve_s    = boundary_s && empty_s;

    // Next-state for pointers, half-frame timer, presented sample and sticky flags.
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        cnt_d      = cnt_q;
        sample_d   = sample_q;
        strobe_d   = 1'b0;
        lr_d       = lr_q;
        started_d  = started_q;
        underrun_d = underrun_q;
        overflow_d = overflow_q;

        if (wr_accept_s) begin
            wptr_d = wptr_q + PW'(1);
        end else begin
            wptr_d = wptr_q;
        end

        // started_q marks that a boundary already occurred, so the first one lands on left.
        if (!enable) begin
            cnt_d     = {CW{1'b0}};
            lr_d      = 1'b0;
            started_d = 1'b0;
        end else if (boundary_s) begin
            cnt_d     = {CW{1'b0}};
            strobe_d  = 1'b1;
            lr_d      = started_q ? ~lr_q : 1'b0;
            started_d = 1'b1;
        end else begin
            cnt_d     = cnt_q + CW'(1);
        end

        if (pop_s) begin
            sample_d = mem_q[rptr_q[DEPTH_LOG2-1:0]];
            rptr_d   = rptr_q + PW'(1);
        end else if (starve_s && (UNDERRUN_ZERO != 0)) begin
            sample_d = {WIDTH{1'b0}};
        end else begin
            sample_d = sample_q;
        end

        // A set event in the same cycle as flags_clr takes priority.
        if (starve_s) begin
            underrun_d = 1'b1;
        end else if (flags_clr) begin
            underrun_d = 1'b0;
        end else begin
            underrun_d = underrun_q;
        end

        if (wr_drop_s) begin
            overflow_d = 1'b1;
        end else if (flags_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Control and output state registers.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            wptr_q     <= {PW{1'b0}};
            rptr_q     <= {PW{1'b0}};
            cnt_q      <= {CW{1'b0}};
            sample_q   <= {WIDTH{1'b0}};
            strobe_q   <= 1'b0;
            lr_q       <= 1'b0;
            started_q  <= 1'b0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            sample_q   <= sample_d;
            strobe_q   <= strobe_d;
            lr_q       <= lr_d;
            started_q  <= started_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage; cleared on reset so no stale sample survives.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (wr_accept_s) begin
            mem_q[wptr_q[DEPTH_LOG2-1:0]] <= wr_data;
        end else begin
            mem_q <= mem_q;
        end
    end

    assign full          = full_s;
    assign empty         = empty_s;
    assign level         = level_s;
    assign sample        = sample_q;
    assign sample_strobe = strobe_q;
    assign lr            = lr_q;
    assign underrun      = underrun_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_i2s_sample_feeder.sv
// Directed bench for i2s_sample_feeder: one zero-on-underrun instance and one
// hold-on-underrun instance share all inputs.
module tb_i2s_sample_feeder;

    logic        clk;
    logic        resetq;
    logic        enable;
    logic [15:0] wr_data;
    logic        wr_en;
    logic        flags_clr;

    logic        full, empty, sample_strobe, lr, underrun, overflow;
    logic [4:0]  level;
    logic [15:0] sample;

    logic        full2, empty2, strobe2, lr2, underrun2, overflow2;
    logic [4:0]  level2;
    logic [15:0] sample2;

    int checks = 0;
    int errors = 0;

    i2s_sample_feeder #(.WIDTH(16), .DEPTH_LOG2(4), .UNDERRUN_ZERO(1)) dut (
        .clk(clk), .resetq(resetq), .enable(enable), .wr_data(wr_data), .wr_en(wr_en),
        .full(full), .empty(empty), .level(level), .sample(sample),
        .sample_strobe(sample_strobe), .lr(lr), .underrun(underrun),
        .overflow(overflow), .flags_clr(flags_clr)
    );

    i2s_sample_feeder #(.WIDTH(16), .DEPTH_LOG2(4), .UNDERRUN_ZERO(0)) dut_hold (
        .clk(clk), .resetq(resetq), .enable(enable), .wr_data(wr_data), .wr_en(wr_en),
        .full(full2), .empty(empty2), .level(level2), .sample(sample2),
        .sample_strobe(strobe2), .lr(lr2), .underrun(underrun2),
        .overflow(overflow2), .flags_clr(flags_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetq = 1'b0; enable = 1'b0; wr_data = 16'h0000; wr_en = 1'b0; flags_clr = 1'b0;
        #2;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
        checks++; if ({sample_strobe, lr, underrun, overflow} !== 4'b0000) begin errors++;
            $display("FAIL reset_flags: got %b want 0000", {sample_strobe, lr, underrun, overflow}); end
        checks++; if (sample !== 16'h0000) begin errors++; $display("FAIL reset_sample: got %h want 0000", sample); end
        @(negedge clk);
        resetq = 1'b1;
        step();
    endtask

    task automatic test_basic();
        wr_en = 1'b1; wr_data = 16'h1111; step();
        wr_data = 16'h2222; step();
        wr_en = 1'b0;
        checks++; if (level !== 5'd2) begin errors++; $display("FAIL basic_level: got %0d want 2", level); end
        enable = 1'b1;
        for (int i = 1; i < 16; i++) begin
            step();
            checks++; if (sample_strobe !== 1'b0) begin errors++; $display("FAIL basic_early_strobe: cycle %0d got 1 want 0", i); end
        end
        step();
        checks++; if (sample_strobe !== 1'b1) begin errors++; $display("FAIL basic_strobe16: got %b want 1", sample_strobe); end
        checks++; if (sample !== 16'h1111) begin errors++; $display("FAIL basic_sample_l: got %h want 1111", sample); end
        checks++; if (lr !== 1'b0) begin errors++; $display("FAIL basic_lr_l: got %b want 0", lr); end
        step();
        checks++; if (sample_strobe !== 1'b0) begin errors++; $display("FAIL basic_strobe_width: got %b want 0", sample_strobe); end
        repeat (15) step();
        checks++; if (sample_strobe !== 1'b1) begin errors++; $display("FAIL basic_strobe32: got %b want 1", sample_strobe); end
        checks++; if (sample !== 16'h2222) begin errors++; $display("FAIL basic_sample_r: got %h want 2222", sample); end
        checks++; if (lr !== 1'b1) begin errors++; $display("FAIL basic_lr_r: got %b want 1", lr); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL basic_level_end: got %0d want 0", level); end
        enable = 1'b0;
        step();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 16'h0100 + 16'(i); step();
        end
        wr_en = 1'b0;
        checks++; if (full !== 1'b1 || level !== 5'd16) begin errors++; $display("FAIL fill: full %b level %0d want 1/16", full, level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_no_ovf: got %b want 0", overflow); end
        wr_en = 1'b1; wr_data = 16'hDEAD; step();
        wr_en = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL ovf_level: got %0d want 16", level); end
        flags_clr = 1'b1; step(); flags_clr = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    endtask

    task automatic test_write_during_pop();
        enable = 1'b1;
        repeat (15) step();
        wr_en = 1'b1; wr_data = 16'hBEEF; flags_clr = 1'b1;
        step();
        wr_en = 1'b0; flags_clr = 1'b0;
        checks++; if (sample_strobe !== 1'b1 || sample !== 16'h0100) begin errors++;
            $display("FAIL pop_full: strobe %b sample %h want 1/0100", sample_strobe, sample); end
        checks++; if (lr !== 1'b0) begin errors++; $display("FAIL pop_full_lr: got %b want 0", lr); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL set_beats_clr: got %b want 1", overflow); end
        checks++; if (level !== 5'd15 || full !== 1'b0) begin errors++;
            $display("FAIL pop_full_level: level %0d full %b want 15/0", level, full); end
        for (int k = 1; k < 16; k++) begin
            repeat (16) step();
            checks++; if (sample_strobe !== 1'b1 || sample !== 16'h0100 + 16'(k) || lr !== k[0]) begin errors++;
                $display("FAIL drain_%0d: strobe %b sample %h lr %b want 1/%h/%b", k, sample_strobe, sample, lr, 16'h0100 + 16'(k), k[0]); end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b want 1", empty); end
    endtask

    task automatic test_underrun();
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_pre: got %b want 0", underrun); end
        repeat (16) step();
        checks++; if (sample_strobe !== 1'b1 || sample !== 16'h0000 || lr !== 1'b0 || underrun !== 1'b1) begin errors++;
            $display("FAIL underrun_zero_l: strobe %b sample %h lr %b ur %b want 1/0000/0/1", sample_strobe, sample, lr, underrun); end
        checks++; if (sample2 !== 16'h010F || underrun2 !== 1'b1) begin errors++;
            $display("FAIL underrun_hold_l: sample %h ur %b want 010F/1", sample2, underrun2); end
        repeat (16) step();
        checks++; if (sample_strobe !== 1'b1 || sample !== 16'h0000 || lr !== 1'b1) begin errors++;
            $display("FAIL underrun_zero_r: strobe %b sample %h lr %b want 1/0000/1", sample_strobe, sample, lr); end
        checks++; if (sample2 !== 16'h010F || lr2 !== 1'b1) begin errors++;
            $display("FAIL underrun_hold_r: sample %h lr %b want 010F/1", sample2, lr2); end
    endtask

    task automatic test_write_at_boundary();
        flags_clr = 1'b1; step(); flags_clr = 1'b0;
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_clear: got %b want 0", underrun); end
        repeat (14) step();
        wr_en = 1'b1; wr_data = 16'h0ABC; step(); wr_en = 1'b0;
        checks++; if (sample_strobe !== 1'b1 || underrun !== 1'b1 || sample !== 16'h0000) begin errors++;
            $display("FAIL wb_boundary: strobe %b ur %b sample %h want 1/1/0000", sample_strobe, underrun, sample); end
        checks++; if (level !== 5'd1 || lr !== 1'b0) begin errors++; $display("FAIL wb_level: level %0d lr %b want 1/0", level, lr); end
        repeat (15) step();
        checks++; if (sample_strobe !== 1'b0) begin errors++; $display("FAIL wb_early: got %b want 0", sample_strobe); end
        step();
        checks++; if (sample_strobe !== 1'b1 || sample !== 16'h0ABC || lr !== 1'b1) begin errors++;
            $display("FAIL wb_next: strobe %b sample %h lr %b want 1/0ABC/1", sample_strobe, sample, lr); end
        checks++; if (sample2 !== 16'h0ABC || level !== 5'd0) begin errors++;
            $display("FAIL wb_next_hold: sample %h level %0d want 0ABC/0", sample2, level); end
    endtask

    task automatic test_reset_mid();
        enable = 1'b0; step();
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 16'h0501 + 16'(i); step();
        end
        wr_en = 1'b0; enable = 1'b1;
        repeat (3) step();
        checks++; if (level !== 5'd5) begin errors++; $display("FAIL mid_level: got %0d want 5", level); end
        resetq = 1'b0;
        #1;
        checks++; if (empty !== 1'b1 || level !== 5'd0 || full !== 1'b0) begin errors++;
            $display("FAIL mid_reset_fifo: empty %b level %0d full %b want 1/0/0", empty, level, full); end
        checks++; if (sample !== 16'h0000 || {sample_strobe, lr, underrun, overflow} !== 4'b0000) begin errors++;
            $display("FAIL mid_reset_out: sample %h flags %b want 0000/0000", sample, {sample_strobe, lr, underrun, overflow}); end
        enable = 1'b0;
        @(negedge clk);
        resetq = 1'b1;
        step();
        enable = 1'b1;
        for (int i = 1; i < 16; i++) begin
            step();
            checks++; if (sample_strobe !== 1'b0) begin errors++; $display("FAIL post_reset_early: cycle %0d got 1 want 0", i); end
        end
        step();
        checks++; if (sample_strobe !== 1'b1 || lr !== 1'b0 || underrun !== 1'b1 || sample !== 16'h0000) begin errors++;
            $display("FAIL post_reset_first: strobe %b lr %b ur %b sample %h want 1/0/1/0000", sample_strobe, lr, underrun, sample); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_write_during_pop();
        test_underrun();
        test_write_at_boundary();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
